// File: rtl/alu_exec_seq.sv
// alu_exec_seq: ALU-control decode plus registered execute with iterative multiply
// (and restoring divide when ALU_EXEC_DIV_EN is defined); valid/ready on both sides.
// Ports: clk, rst_n (async, active low)
//        in_valid/in_ready, alu_op[1:0], funct[FUNCT_W-1:0], a, b  -- request side
//        out_valid/out_ready, result_lo, result_hi, jr_flag, illegal -- result side
// Config macro: ALU_EXEC_DIV_EN (funct 0110 runs a WIDTH-cycle divide; else illegal ADD)
module alu_exec_seq #(
   parameter int WIDTH   = 32,
   parameter int FUNCT_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         alu_op,
   input  logic [FUNCT_W-1:0] funct,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result_lo,
   output logic [WIDTH-1:0]   result_hi,
   output logic               jr_flag,
   output logic               illegal
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SLT, OP_MUL, OP_DIV, OP_JR
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
`ifdef ALU_EXEC_DIV_EN
      S_DIV  = 2'd2,
`endif
      S_DONE = 2'd3
   } state_e;

   state_e           r_state;
   logic             r_valid;
   logic             r_jr;
   logic             r_ill;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_opnd;
   logic [CW-1:0]    r_cnt;

   op_e              w_op;
   logic             w_ill;
   logic             w_hi_zero;
   logic             w_accept;
   logic [WIDTH-1:0] w_res;
   logic [WIDTH:0]   w_msum;

   assign in_ready  = (r_state == S_IDLE) && (!r_valid || out_ready);
   assign w_accept  = in_valid && in_ready;
   assign out_valid = r_valid;
   assign result_lo = r_lo;
   assign result_hi = r_hi;
   assign jr_flag   = r_jr;
   assign illegal   = r_ill;

   // funct bits above [3:0] must be zero for any legal R-type code
   assign w_hi_zero = ((funct >> 4) == '0);

   always_comb begin
      w_op  = OP_ADD;
      w_ill = 1'b0;
      case (alu_op)
         2'b11: w_op = OP_ADD;
         2'b10: w_op = OP_SLT;
         2'b01: w_op = OP_SUB;
         default: begin
            if (!w_hi_zero) begin
               w_ill = 1'b1;
            end else begin
               case (funct[3:0])
                  4'h0: w_op = OP_ADD;
                  4'h1: w_op = OP_SUB;
                  4'h2: w_op = OP_AND;
                  4'h3: w_op = OP_OR;
                  4'h4: w_op = OP_SLT;
                  4'h5: w_op = OP_MUL;
`ifdef ALU_EXEC_DIV_EN
                  4'h6: w_op = OP_DIV;
`endif
                  4'h8: w_op = OP_JR;
                  default: w_ill = 1'b1;
               endcase
            end
         end
      endcase
   end

   always_comb begin
      w_res = a + b;
      case (w_op)
         OP_SUB: w_res = a - b;
         OP_AND: w_res = a & b;
         OP_OR:  w_res = a | b;
         OP_SLT: w_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_JR:  w_res = '0;
         default: w_res = a + b;
      endcase
   end

   // shift-add step: hi:lo holds partial product, lo shifts out multiplier bits
   assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

`ifdef ALU_EXEC_DIV_EN
   logic [WIDTH:0] w_rsh;
   logic [WIDTH:0] w_diff;

   // restoring step: hi is the remainder, lo shifts dividend out and quotient in
   assign w_rsh  = {r_hi, r_lo[WIDTH-1]};
   assign w_diff = w_rsh - {1'b0, r_opnd};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_valid <= 1'b0;
         r_jr    <= 1'b0;
         r_ill   <= 1'b0;
         r_lo    <= '0;
         r_hi    <= '0;
         r_opnd  <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_jr  <= 1'b0;
                  r_ill <= w_ill;
                  case (w_op)
                     OP_MUL: begin
                        r_state <= S_MUL;
                        r_valid <= 1'b0;
                        r_opnd  <= a;
                        r_hi    <= '0;
                        r_lo    <= b;
                        r_cnt   <= CW'(WIDTH - 1);
                     end
`ifdef ALU_EXEC_DIV_EN
                     OP_DIV: begin
                        if (b == '0) begin
                           r_state <= S_DONE;
                           r_valid <= 1'b1;
                           r_ill   <= 1'b1;
                           r_lo    <= '1;
                           r_hi    <= a;
                        end else begin
                           r_state <= S_DIV;
                           r_valid <= 1'b0;
                           r_opnd  <= b;
                           r_hi    <= '0;
                           r_lo    <= a;
                           r_cnt   <= CW'(WIDTH - 1);
                        end
                     end
`endif
                     default: begin
                        r_valid <= 1'b1;
                        r_jr    <= (w_op == OP_JR);
                        r_lo    <= w_res;
                        r_hi    <= '0;
                     end
                  endcase
               end else if (r_valid && out_ready) begin
                  r_valid <= 1'b0;
                  r_jr    <= 1'b0;
                  r_ill   <= 1'b0;
               end
            end
            S_MUL: begin
               r_hi  <= w_msum[WIDTH:1];
               r_lo  <= {w_msum[0], r_lo[WIDTH-1:1]};
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
                  r_state <= S_DONE;
                  r_valid <= 1'b1;
               end
            end
`ifdef ALU_EXEC_DIV_EN
            S_DIV: begin
               if (!w_diff[WIDTH]) begin
                  r_hi <= w_diff[WIDTH-1:0];
                  r_lo <= {r_lo[WIDTH-2:0], 1'b1};
               end else begin
                  r_hi <= w_rsh[WIDTH-1:0];
                  r_lo <= {r_lo[WIDTH-2:0], 1'b0};
               end
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
                  r_state <= S_DONE;
                  r_valid <= 1'b1;
               end
            end
`endif
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
                  r_valid <= 1'b0;
                  r_jr    <= 1'b0;
                  r_ill   <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_seq.sv
// tb_alu_exec_seq: table vectors, hand sequences and a random run against
// an arithmetic reference model for alu_exec_seq at WIDTH=8.
module tb_alu_exec_seq;

   localparam int W  = 8;
   localparam int FW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    alu_op = '0;
   logic [FW-1:0] funct = '0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result_lo;
   logic [W-1:0]  result_hi;
   logic          jr_flag;
   logic          illegal;

   int checks = 0;
   int errors = 0;

   alu_exec_seq #(.WIDTH(W), .FUNCT_W(FW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .funct(funct), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result_lo(result_lo), .result_hi(result_hi),
      .jr_flag(jr_flag), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] op;
      logic [3:0] f;
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] lo;
      logic [7:0] hi;
      logic       jr;
      logic       ill;
      int         lat;
   } vec_t;

   vec_t tbl[15];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: the arithmetic meaning of each decoded operation
   function automatic void model(
      input  logic [1:0] op, input logic [3:0] f,
      input  logic [7:0] x,  input logic [7:0] y,
      output logic [7:0] lo, output logic [7:0] hi,
      output logic jr, output logic ill, output int lat);
      int p;
      lo = x + y; hi = 0; jr = 0; ill = 0; lat = 1;
      if (op == 2'b10)
         lo = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
      else if (op == 2'b01)
         lo = x - y;
      else if (op == 2'b00) begin
         case (f)
            4'h0: lo = x + y;
            4'h1: lo = x - y;
            4'h2: lo = x & y;
            4'h3: lo = x | y;
            4'h4: lo = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
            4'h5: begin
               p = int'(x) * int'(y);
               lo = p[7:0]; hi = p[15:8]; lat = W + 1;
            end
`ifdef ALU_EXEC_DIV_EN
            4'h6: begin
               if (y == 0) begin
                  lo = 8'hFF; hi = x; ill = 1; lat = 1;
               end else begin
                  lo = x / y; hi = x % y; lat = W + 1;
               end
            end
`endif
            4'h8: begin lo = 0; jr = 1; end
            default: ill = 1;
         endcase
      end
   endfunction

   task automatic run_op(
      input logic [1:0] op, input logic [3:0] f,
      input logic [7:0] x, input logic [7:0] y,
      input logic [7:0] elo, input logic [7:0] ehi,
      input logic ejr, input logic eill,
      input int elat, input int hold, input string nm);
      int n;
      int lat;
      n = 0;
      while (!in_ready && n < 100) begin step(); n++; end
      if (!in_ready) begin
         chk({nm, "_rdywait"}, int'(in_ready), 1);
         return;
      end
      alu_op = op; funct = f; a = x; b = y;
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom);
      out_ready = (hold == 0);
      lat = 1;
      while (!out_valid && lat < 100) begin step(); lat++; end
      chk({nm, "_lat"}, lat, elat);
      chk({nm, "_lo"}, int'(result_lo), int'(elo));
      chk({nm, "_hi"}, int'(result_hi), int'(ehi));
      chk({nm, "_jr"}, int'(jr_flag), int'(ejr));
      chk({nm, "_ill"}, int'(illegal), int'(eill));
      for (int h = 0; h < hold; h++) begin
         step();
         chk({nm, "_hold_v"}, int'(out_valid), 1);
         chk({nm, "_hold_lo"}, int'(result_lo), int'(elo));
         chk({nm, "_hold_hi"}, int'(result_hi), int'(ehi));
         chk({nm, "_hold_fl"}, int'({jr_flag, illegal}), int'({ejr, eill}));
         chk({nm, "_hold_rdy"}, int'(in_ready), 0);
      end
      out_ready = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0] rop;
      logic [3:0] rf;
      logic [7:0] rx, ry, mlo, mhi;
      logic mjr, mill;
      int mlat, busy, n;

      tbl[0]  = '{2'b00, 4'h1, 8'h05, 8'h07, 8'hFE, 8'h00, 1'b0, 1'b0, 1};
      tbl[1]  = '{2'b00, 4'h4, 8'hFF, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1};
      tbl[2]  = '{2'b10, 4'h0, 8'hFF, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1};
      tbl[3]  = '{2'b00, 4'h8, 8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 1'b0, 1};
      tbl[4]  = '{2'b00, 4'hF, 8'h03, 8'h04, 8'h07, 8'h00, 1'b0, 1'b1, 1};
      tbl[5]  = '{2'b11, 4'h5, 8'hF0, 8'h20, 8'h10, 8'h00, 1'b0, 1'b0, 1};
      tbl[6]  = '{2'b01, 4'h0, 8'h00, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1};
      tbl[7]  = '{2'b00, 4'h2, 8'hCC, 8'hAA, 8'h88, 8'h00, 1'b0, 1'b0, 1};
      tbl[8]  = '{2'b00, 4'h3, 8'hCC, 8'hAA, 8'hEE, 8'h00, 1'b0, 1'b0, 1};
      tbl[9]  = '{2'b00, 4'h0, 8'h80, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 1};
      tbl[10] = '{2'b00, 4'h4, 8'h01, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1};
      tbl[11] = '{2'b00, 4'h5, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 9};
      tbl[12] = '{2'b00, 4'h5, 8'h0C, 8'h0B, 8'h84, 8'h00, 1'b0, 1'b0, 9};
`ifdef ALU_EXEC_DIV_EN
      tbl[13] = '{2'b00, 4'h6, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 9};
      tbl[14] = '{2'b00, 4'h6, 8'd100, 8'd0, 8'hFF, 8'd100, 1'b0, 1'b1, 1};
`else
      tbl[13] = '{2'b00, 4'h6, 8'd100, 8'd7, 8'd107, 8'd0, 1'b0, 1'b1, 1};
      tbl[14] = '{2'b00, 4'h6, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1};
`endif

      // reset state
      step(); step();
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_ready", int'(in_ready), 1);
      chk("rst_lo", int'(result_lo), 0);
      chk("rst_hi", int'(result_hi), 0);
      chk("rst_flags", int'({jr_flag, illegal}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // table vectors
      for (int i = 0; i < 15; i++)
         run_op(tbl[i].op, tbl[i].f, tbl[i].x, tbl[i].y,
                tbl[i].lo, tbl[i].hi, tbl[i].jr, tbl[i].ill,
                tbl[i].lat, 0, $sformatf("tbl%0d", i));

      // MULT with junk requests while busy, then held result
      in_valid = 1'b0; out_ready = 1'b1;
      step(); step();
      alu_op = 2'b00; funct = 4'h5; a = 8'hFF; b = 8'hFF;
      in_valid = 1'b1; out_ready = 1'b0;
      step();
      funct = 4'h0; a = 8'h01; b = 8'h01;
      busy = 0; n = 1;
      while (!out_valid && n < 100) begin
         if (!in_ready) busy++;
         step(); n++;
      end
      in_valid = 1'b0;
      chk("mul_busy", busy, 8);
      chk("mul_lat", n, 9);
      chk("mul_lo", int'(result_lo), 8'h01);
      chk("mul_hi", int'(result_hi), 8'hFE);
      for (int h = 0; h < 3; h++) begin
         step();
         chk("mul_hold_v", int'(out_valid), 1);
         chk("mul_hold_res", int'({result_hi, result_lo}), 16'hFE01);
         chk("mul_hold_rdy", int'(in_ready), 0);
      end
      out_ready = 1'b1;
      step();
      chk("mul_rel_v", int'(out_valid), 0);
      chk("mul_rel_rdy", int'(in_ready), 1);

      // reset mid-multiply
      alu_op = 2'b00; funct = 4'h5; a = 8'hE7; b = 8'h9D;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step(); step();
      rst_n = 1'b0;
      #2;
      chk("abort_v", int'(out_valid), 0);
      chk("abort_rdy", int'(in_ready), 1);
      chk("abort_res", int'({result_hi, result_lo}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("abort_rel_v", int'(out_valid), 0);
      chk("abort_rel_rdy", int'(in_ready), 1);
      run_op(2'b00, 4'h0, 8'd2, 8'd2, 8'd4, 8'd0, 1'b0, 1'b0, 1, 0, "post_abort");

      // randomized against the reference model, with random backpressure
      for (int i = 0; i < 150; i++) begin
         rop = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0)
            rf = 4'($urandom);
         else
            case ($urandom_range(0, 7))
               0: rf = 4'h0; 1: rf = 4'h1; 2: rf = 4'h2; 3: rf = 4'h3;
               4: rf = 4'h4; 5: rf = 4'h5; 6: rf = 4'h6; default: rf = 4'h8;
            endcase
         rx = 8'($urandom);
         ry = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         model(rop, rf, rx, ry, mlo, mhi, mjr, mill, mlat);
         run_op(rop, rf, rx, ry, mlo, mhi, mjr, mill, mlat,
                int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
      end

      step(); step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
